// File: rtl/tetris_pkg.sv
// Shared playfield geometry and line-clear FSM encodings.
// The state encodings also drive the debug LEDs.
package tetris_pkg;

    localparam int COLS    = 10;
    localparam int ROWS    = 20;
    localparam int X_W     = 4;
    localparam int Y_W     = 5;
    localparam int TOTAL_W = 10;
    localparam int IDX_W   = 6;   // signed row index, so -1 is representable

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } clr_state_e;

endpackage

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: walks src/dst from the bottom row upward and issues
// row-copy / row-zero strobes to the storage array.
// It also keeps the pass counter and the cumulative saturating line total.
module line_clear_ctrl
    import tetris_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wipe,
    input  logic               start,
    input  logic               row_full,
    output logic               idle,
    output logic               copy_en,
    output logic               zero_en,
    output logic [Y_W-1:0]     src_row,
    output logic [Y_W-1:0]     dst_row,
    output logic               busy,
    output logic               done,
    output logic [Y_W-1:0]     lines_cleared,
    output logic [TOTAL_W-1:0] total_lines
);

    clr_state_e                state_q, state_d;
    logic signed [IDX_W-1:0]   src_q, src_d;
    logic signed [IDX_W-1:0]   dst_q, dst_d;
    logic [Y_W-1:0]            cnt_q, cnt_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [Y_W-1:0]            lines_q, lines_d;
    logic [TOTAL_W-1:0]        total_q, total_d;
    logic [TOTAL_W:0]          total_sum;

    // Next-state and next-output computation; wipe overrides everything.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        lines_d   = lines_q;
        total_d   = total_q;
        total_sum = {1'b0, total_q} + (TOTAL_W + 1)'(cnt_q);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SCAN;
                    src_d   = IDX_W'(ROWS - 1);
                    dst_d   = IDX_W'(ROWS - 1);
                    cnt_d   = '0;
                end
            end
            ST_SCAN: begin
                if (row_full) begin
                    cnt_d = cnt_q + Y_W'(1);
                end else begin
                    dst_d = dst_q - IDX_W'(1);
                end
                src_d = src_q - IDX_W'(1);
                if (src_q == '0) begin
                    state_d = (cnt_d != '0) ? ST_FILL : ST_DONE;
                end
            end
            ST_FILL: begin
                dst_d = dst_q - IDX_W'(1);
                if (dst_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                lines_d = cnt_q;
                total_d = total_sum[TOTAL_W] ? '1 : total_sum[TOTAL_W-1:0];
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (wipe) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            lines_d = '0;
            total_d = '0;
        end
        busy_d = (state_d == ST_SCAN) || (state_d == ST_FILL);
    end

    // FSM and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lines_q <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lines_q <= lines_d;
            total_q <= total_d;
        end
    end

    assign idle          = (state_q == ST_IDLE);
    assign copy_en       = (state_q == ST_SCAN) && !row_full;
    assign zero_en       = (state_q == ST_FILL);
    assign src_row       = src_q[Y_W-1:0];
    assign dst_row       = dst_q[Y_W-1:0];
    assign busy          = busy_q;
    assign done          = done_q;
    assign lines_cleared = lines_q;
    assign total_lines   = total_q;

endmodule

// File: rtl/board_store.sv
// Playfield occupancy store: ROWS x COLS cell flops, two combinational read
// ports (game logic and VGA painter), a lock-write port and the line-clear
// engine. Out-of-range reads return 1 so they behave as walls.
module board_store
    import tetris_pkg::*;
(
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [X_W-1:0]     board_rx,
    input  logic [Y_W-1:0]     board_ry,
    output logic               board_rdata,
    input  logic               board_we,
    input  logic [X_W-1:0]     board_wx,
    input  logic [Y_W-1:0]     board_wy,
    input  logic               board_wdata,
    input  logic [X_W-1:0]     vga_x,
    input  logic [Y_W-1:0]     vga_y,
    output logic               vga_cell,
    input  logic               board_wipe,
    input  logic               clear_start,
    output logic               clear_busy,
    output logic               clear_done,
    output logic [Y_W-1:0]     lines_cleared,
    output logic [TOTAL_W-1:0] total_lines
);

    logic [COLS-1:0] rows_q [ROWS];
    logic [COLS-1:0] rows_d [ROWS];
    logic            idle;
    logic            copy_en;
    logic            zero_en;
    logic            row_full;
    logic            wr_ok;
    logic [Y_W-1:0]  src_row;
    logic [Y_W-1:0]  dst_row;

    assign wr_ok    = board_we && idle &&
                      (board_wx < X_W'(COLS)) && (board_wy < Y_W'(ROWS));
    assign row_full = (src_row < Y_W'(ROWS)) && (&rows_q[src_row]);

    line_clear_ctrl u_ctrl (
        .clk           (CLOCK_50),
        .rst           (reset),
        .wipe          (board_wipe),
        .start         (clear_start),
        .row_full      (row_full),
        .idle          (idle),
        .copy_en       (copy_en),
        .zero_en       (zero_en),
        .src_row       (src_row),
        .dst_row       (dst_row),
        .busy          (clear_busy),
        .done          (clear_done),
        .lines_cleared (lines_cleared),
        .total_lines   (total_lines)
    );

    // Next board contents: lock write, compaction copy/zero, wipe last.
    always_comb begin
        rows_d = rows_q;
        if (wr_ok) begin
            rows_d[board_wy][board_wx] = board_wdata;
        end
        if (copy_en) begin
            rows_d[dst_row] = rows_q[src_row];
        end
        if (zero_en) begin
            rows_d[dst_row] = '0;
        end
        if (board_wipe) begin
            for (int unsigned i = 0; i < ROWS; i++) begin
                rows_d[i] = '0;
            end
        end
    end

    // Cell storage.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < ROWS; i++) begin
                rows_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < ROWS; i++) begin
                rows_q[i] <= rows_d[i];
            end
        end
    end

    assign board_rdata = ((board_rx < X_W'(COLS)) && (board_ry < Y_W'(ROWS)))
                         ? rows_q[board_ry][board_rx] : 1'b1;
    assign vga_cell    = ((vga_x < X_W'(COLS)) && (vga_y < Y_W'(ROWS)))
                         ? rows_q[vga_y][vga_x] : 1'b1;

endmodule

// File: tb/tb_board_store.sv
// Bench for board_store: directed scenarios plus randomized boards, checked
// against a row-list model of the playfield and line-clear rules.
module tb_board_store;

    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int TMAX = 1023;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [3:0] board_rx, board_wx, vga_x;
    logic [4:0] board_ry, board_wy, vga_y;
    logic       board_rdata, board_we, board_wdata, vga_cell;
    logic       board_wipe, clear_start, clear_busy, clear_done;
    logic [4:0] lines_cleared;
    logic [9:0] total_lines;

    int tests = 0;
    int fails = 0;

    logic [COLS-1:0] mrow [ROWS];
    int mtotal;
    int mlines;

    board_store dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .board_rx      (board_rx),
        .board_ry      (board_ry),
        .board_rdata   (board_rdata),
        .board_we      (board_we),
        .board_wx      (board_wx),
        .board_wy      (board_wy),
        .board_wdata   (board_wdata),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_cell      (vga_cell),
        .board_wipe    (board_wipe),
        .clear_start   (clear_start),
        .clear_busy    (clear_busy),
        .clear_done    (clear_done),
        .lines_cleared (lines_cleared),
        .total_lines   (total_lines)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_zero();
        for (int y = 0; y < ROWS; y++) mrow[y] = '0;
        mtotal = 0;
        mlines = 0;
    endtask

    // Reference clear: keep non-full rows in bottom-up order, stack them at
    // the bottom, empty rows on top.
    function automatic int mdl_clear();
        logic [COLS-1:0] kept[$];
        int cnt;
        for (int y = ROWS - 1; y >= 0; y--) begin
            if (mrow[y] != {COLS{1'b1}}) kept.push_back(mrow[y]);
        end
        cnt = ROWS - kept.size();
        for (int y = ROWS - 1; y >= 0; y--) begin
            mrow[y] = ((ROWS - 1 - y) < kept.size()) ? kept[ROWS - 1 - y] : '0;
        end
        mlines = cnt;
        mtotal = (mtotal + cnt > TMAX) ? TMAX : mtotal + cnt;
        return cnt;
    endfunction

    // Starts and ends at a negedge; assumes the engine is idle.
    task automatic wr(input int x, input int y, input logic d);
        board_we    = 1'b1;
        board_wx    = 4'(x);
        board_wy    = 5'(y);
        board_wdata = d;
        @(negedge CLOCK_50);
        board_we = 1'b0;
        if (x < COLS && y < ROWS) mrow[y][x] = d;
    endtask

    task automatic fill_row(input int y);
        for (int x = 0; x < COLS; x++) wr(x, y, 1'b1);
    endtask

    task automatic check_board(input string tag);
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                board_rx = 4'(x);
                board_ry = 5'(y);
                vga_x    = 4'(COLS - 1 - x);
                vga_y    = 5'(ROWS - 1 - y);
                #1;
                chk({tag, "_rd"}, 32'(board_rdata), 32'(mrow[y][x]));
                chk({tag, "_vga"}, 32'(vga_cell), 32'(mrow[ROWS - 1 - y][COLS - 1 - x]));
            end
        end
        @(negedge CLOCK_50);
    endtask

    task automatic run_clear(input string tag);
        int exp_cnt;
        int k;
        exp_cnt = mdl_clear();
        clear_start = 1'b1;
        @(negedge CLOCK_50);
        clear_start = 1'b0;
        chk({tag, "_busy"}, 32'(clear_busy), 32'd1);
        k = 0;
        while (!clear_done && k < 100) begin
            @(negedge CLOCK_50);
            k++;
        end
        chk({tag, "_latency"}, 32'(k), 32'(ROWS + exp_cnt + 1));
        chk({tag, "_lines"}, 32'(lines_cleared), 32'(mlines));
        chk({tag, "_total"}, 32'(total_lines), 32'(mtotal));
        @(negedge CLOCK_50);
        chk({tag, "_done_pulse"}, 32'(clear_done), 32'd0);
        chk({tag, "_busy_end"}, 32'(clear_busy), 32'd0);
    endtask

    initial begin
        int dn;
        logic [COLS-1:0] pat;
        reset       = 1'b1;
        board_rx    = '0;
        board_ry    = '0;
        board_we    = 1'b0;
        board_wx    = '0;
        board_wy    = '0;
        board_wdata = 1'b0;
        vga_x       = '0;
        vga_y       = '0;
        board_wipe  = 1'b0;
        clear_start = 1'b0;
        model_zero();
        #12;
        chk("rst_busy", 32'(clear_busy), 32'd0);
        chk("rst_done", 32'(clear_done), 32'd0);
        chk("rst_lines", 32'(lines_cleared), 32'd0);
        chk("rst_total", 32'(total_lines), 32'd0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        check_board("rst");

        // Single write: invisible before the edge, visible after.
        board_rx = 4'd4;
        board_ry = 5'd19;
        vga_x    = 4'd4;
        vga_y    = 5'd19;
        board_we = 1'b1; board_wx = 4'd4; board_wy = 5'd19; board_wdata = 1'b1;
        #1;
        chk("wr_before_edge", 32'(board_rdata), 32'd0);
        @(negedge CLOCK_50);
        board_we = 1'b0;
        mrow[19][4] = 1'b1;
        chk("wr_after_edge", 32'(board_rdata), 32'd1);
        chk("wr_vga", 32'(vga_cell), 32'd1);
        board_rx = 4'd10; board_ry = 5'd0; vga_x = 4'd0; vga_y = 5'd20;
        #1;
        chk("wall_x10", 32'(board_rdata), 32'd1);
        chk("wall_y20", 32'(vga_cell), 32'd1);
        board_rx = 4'd15; board_ry = 5'd31; vga_x = 4'd9; vga_y = 5'd19;
        #1;
        chk("wall_far", 32'(board_rdata), 32'd1);
        chk("edge_cell", 32'(vga_cell), 32'd0);
        @(negedge CLOCK_50);
        wr(12, 3, 1'b1);
        wr(3, 25, 1'b1);
        check_board("oob_wr");

        // One full row.
        fill_row(19);
        wr(3, 18, 1'b1);
        run_clear("one_line");
        check_board("one_line");

        // Four full rows with debris above.
        for (int y = 16; y < 20; y++) fill_row(y);
        wr(0, 15, 1'b1);
        wr(9, 14, 1'b1);
        run_clear("four_lines");
        check_board("four_lines");

        // Non-adjacent full rows around a patterned row.
        pat = 10'h155;
        fill_row(19);
        fill_row(17);
        for (int x = 0; x < COLS; x++) wr(x, 18, pat[x]);
        run_clear("split");
        check_board("split");

        // Write and second start during SCAN are ignored.
        fill_row(19);
        wr(5, 10, 1'b1);
        void'(mdl_clear());
        clear_start = 1'b1;
        @(negedge CLOCK_50);
        clear_start = 1'b0;
        board_we = 1'b1; board_wx = 4'd2; board_wy = 5'd0; board_wdata = 1'b1;
        clear_start = 1'b1;
        @(negedge CLOCK_50);
        board_we = 1'b0;
        clear_start = 1'b0;
        dn = 0;
        for (int i = 0; i < 60; i++) begin
            if (clear_done) dn++;
            @(negedge CLOCK_50);
        end
        chk("busy_done_count", 32'(dn), 32'd1);
        chk("busy_lines", 32'(lines_cleared), 32'(mlines));
        chk("busy_total", 32'(total_lines), 32'(mtotal));
        check_board("busy_wr");

        // Wipe mid-SCAN.
        fill_row(19);
        fill_row(12);
        clear_start = 1'b1;
        @(negedge CLOCK_50);
        clear_start = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        board_wipe = 1'b1;
        @(negedge CLOCK_50);
        board_wipe = 1'b0;
        model_zero();
        chk("wipe_busy", 32'(clear_busy), 32'd0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (clear_done) dn++;
            @(negedge CLOCK_50);
        end
        chk("wipe_no_done", 32'(dn), 32'd0);
        chk("wipe_lines", 32'(lines_cleared), 32'd0);
        chk("wipe_total", 32'(total_lines), 32'd0);
        check_board("wipe");

        // Randomized boards, totals accumulate.
        for (int it = 0; it < 10; it++) begin
            int nf;
            nf = int'($urandom_range(0, 3));
            for (int f = 0; f < nf; f++) fill_row(int'($urandom_range(0, ROWS - 1)));
            for (int c = 0; c < 25; c++)
                wr(int'($urandom_range(0, COLS - 1)), int'($urandom_range(0, ROWS - 1)), 1'($urandom));
            run_clear("rand");
            check_board("rand");
        end

        // Full-board clears until the total saturates.
        for (int it = 0; it < 52; it++) begin
            for (int y = 0; y < ROWS; y++) fill_row(y);
            run_clear("full");
        end
        chk("total_sat", 32'(total_lines), 32'(TMAX));
        chk("lines_max", 32'(lines_cleared), 32'(ROWS));
        run_clear("empty");
        check_board("empty");

        // Asynchronous reset mid-FILL.
        for (int y = 16; y < 20; y++) fill_row(y);
        clear_start = 1'b1;
        @(negedge CLOCK_50);
        clear_start = 1'b0;
        repeat (22) @(negedge CLOCK_50);
        chk("prerst_busy", 32'(clear_busy), 32'd1);
        reset = 1'b1;
        board_rx = 4'd0; board_ry = 5'd19;
        #1;
        chk("rst_mid_busy", 32'(clear_busy), 32'd0);
        chk("rst_mid_done", 32'(clear_done), 32'd0);
        chk("rst_mid_lines", 32'(lines_cleared), 32'd0);
        chk("rst_mid_total", 32'(total_lines), 32'd0);
        chk("rst_mid_cell", 32'(board_rdata), 32'd0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        model_zero();
        check_board("rst_mid");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
